// File: rtl/proc_sequencer.sv
// Instruction sequencer: fetches 32-bit instructions, decodes fixed fields, steps the core
// through decode/execute/memory/writeback, and counts retired instructions.
module proc_sequencer #(
   parameter int unsigned          ADDR_W   = 16,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0,
   parameter int unsigned          CNT_W    = 16,
   parameter logic [3:0]           OP_B     = 4'd12,
   parameter logic [3:0]           OP_LDR   = 4'd13,
   parameter logic [3:0]           OP_STR   = 4'd14,
   parameter logic [3:0]           OP_HALT  = 4'd15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run,
   output logic              mem_req,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   input  logic [ADDR_W-1:0] ldst_addr,
   input  logic              cond_pass,
   output logic [3:0]        cond,
   output logic [3:0]        op_code,
   output logic              s_bit,
   output logic [3:0]        dest,
   output logic [3:0]        src1,
   output logic [3:0]        src2,
   output logic [15:0]       im_val,
   output logic [2:0]        sr_ctrl,
   output logic [ADDR_W-1:0] pc,
   output logic              reg_we,
   output logic              flags_we,
   output logic              sel_ldr,
   output logic [31:0]       ldr_data,
   output logic              halted,
   output logic [CNT_W-1:0]  retired,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StHalt   = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         ir_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [31:0]         ldr_q;
   logic [CNT_W-1:0]    retired_q;
   logic [ADDR_W-1:0]   br_target;
   logic                retire;
   logic                is_b, is_ldr, is_str, is_halt;

   // Decode fields come straight from the instruction register
   assign cond    = ir_q[31:28];
   assign op_code = ir_q[27:24];
   assign s_bit   = ir_q[23];
   assign dest    = ir_q[22:19];
   assign src1    = ir_q[18:15];
   assign src2    = ir_q[14:11];
   assign im_val  = ir_q[18:3];
   assign sr_ctrl = ir_q[2:0];

   assign pc       = pc_q;
   assign ldr_data = ldr_q;
   assign retired  = retired_q;
   assign state    = state_q;

   assign is_b    = (op_code == OP_B);
   assign is_ldr  = (op_code == OP_LDR);
   assign is_str  = (op_code == OP_STR);
   assign is_halt = (op_code == OP_HALT);

   // Branch target is the immediate, truncated or zero-extended to the PC width
   if (ADDR_W > 16) begin : g_br_ext
      assign br_target = {{(ADDR_W-16){1'b0}}, im_val};
   end else begin : g_br_trunc
      assign br_target = im_val[ADDR_W-1:0];
   end

   // An instruction retires on writeback, store completion, or branch exit from execute
   assign retire = (state_q == StWb)
                 || ((state_q == StMem) && mem_ready && is_str)
                 || ((state_q == StExec) && is_b);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: IR, PC, load data latch and retire counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir_q      <= '0;
         pc_q      <= RESET_PC;
         ldr_q     <= '0;
         retired_q <= '0;
      end else begin
         if ((state_q == StFetch) && mem_ready) begin
            ir_q <= mem_rdata;
            pc_q <= pc_q + ADDR_W'(1);
         end
         if ((state_q == StExec) && is_b && cond_pass) begin
            pc_q <= br_target;
         end
         if ((state_q == StMem) && mem_ready && is_ldr) begin
            ldr_q <= mem_rdata;
         end
         if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

   // Next-state logic; unused encoding 7 falls back to idle
   always_comb begin
      state_d = StIdle;
      case (state_q)
         StIdle:   state_d = run ? StFetch : StIdle;
         StFetch:  state_d = mem_ready ? StDecode : StFetch;
         StDecode: state_d = StExec;
         StExec: begin
            if (is_halt) begin
               state_d = StHalt;
            end else if (is_b) begin
               state_d = run ? StFetch : StIdle;
            end else if (is_ldr || is_str) begin
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            if (!mem_ready) begin
               state_d = StMem;
            end else if (is_ldr) begin
               state_d = StWb;
            end else begin
               state_d = run ? StFetch : StIdle;
            end
         end
         StWb:     state_d = run ? StFetch : StIdle;
         StHalt:   state_d = StHalt;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs decoded from the current state only
   always_comb begin
      mem_req  = 1'b0;
      mem_rw   = 1'b0;
      mem_addr = pc_q;
      reg_we   = 1'b0;
      flags_we = 1'b0;
      sel_ldr  = 1'b0;
      halted   = 1'b0;
      case (state_q)
         StFetch: mem_req = 1'b1;
         StExec:  flags_we = s_bit && !(is_halt || is_b || is_ldr || is_str);
         StMem: begin
            mem_req  = 1'b1;
            mem_rw   = is_str;
            mem_addr = ldst_addr;
         end
         StWb: begin
            reg_we  = 1'b1;
            sel_ldr = is_ldr;
         end
         StHalt:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: table of single-instruction vectors plus hand-written reset,
// halt and counter-wrap sequences. Memory accesses and writebacks are checked by scoreboard.
module tb_proc_sequencer;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_MEM   = 3'd4;
   localparam logic [2:0] ST_HALT  = 3'd6;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        run = 1'b0;
   logic        mem_req, mem_rw, mem_ready;
   logic [15:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [15:0] ldst_addr = '0;
   logic        cond_pass = 1'b0;
   logic [3:0]  cond, op_code, dest, src1, src2;
   logic        s_bit;
   logic [15:0] im_val;
   logic [2:0]  sr_ctrl;
   logic [15:0] pc;
   logic        reg_we, flags_we, sel_ldr, halted;
   logic [31:0] ldr_data;
   logic [3:0]  retired;
   logic [2:0]  state;

   proc_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .run(run),
      .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ldst_addr(ldst_addr),
      .cond_pass(cond_pass), .cond(cond), .op_code(op_code), .s_bit(s_bit),
      .dest(dest), .src1(src1), .src2(src2), .im_val(im_val), .sr_ctrl(sr_ctrl),
      .pc(pc), .reg_we(reg_we), .flags_we(flags_we), .sel_ldr(sel_ldr),
      .ldr_data(ldr_data), .halted(halted), .retired(retired), .state(state)
   );

   always #5 clk = ~clk;

   // Memory model: word array, programmable wait cycles for fetch and data accesses
   logic [31:0] mem [0:65535];
   int fetch_wait = 0;
   int mem_wait = 0;
   int wait_cnt = 0;
   assign mem_rdata = mem[mem_addr];
   assign mem_ready = !mem_req || (wait_cnt >= ((state == ST_FETCH) ? fetch_wait : mem_wait));
   always @(posedge clk) begin
      if (!mem_req || mem_ready) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   int n_checks = 0;
   int n_fail = 0;
   logic [16:0] acc_q[$];
   logic [4:0]  wb_q[$];
   int          exp_ret = 0;
   logic [15:0] exp_pc = '0;
   logic [31:0] exp_ldr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: completed memory accesses and register writes against expected queues
   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_req && mem_ready) begin
            if (acc_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_access: actual=%0h required=none", {mem_rw, mem_addr});
            end else begin
               check("mem_access", 32'({mem_rw, mem_addr}), 32'(acc_q.pop_front()));
            end
         end
         if (reg_we) begin
            if (wb_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_reg_we: actual=%0h required=none", {sel_ldr, dest});
            end else begin
               check("reg_write", 32'({sel_ldr, dest}), 32'(wb_q.pop_front()));
            end
         end
      end
   end

   typedef struct {
      logic [31:0] instr;
      logic        cp;
      logic [15:0] ldst;
      int          fw;
      int          mw;
      logic        run_v;
      int          lat;
      logic [15:0] next_pc;
      int          n_we;
      int          n_fwe;
      int          ret_inc;
      logic [2:0]  end_st;
   } vec_t;

   function automatic logic [31:0] mk(input logic [3:0] op, input logic s, input logic [3:0] d,
                                      input logic [15:0] im);
      return {4'hE, op, s, d, im, 3'b101};
   endfunction

   // Runs one instruction starting at FETCH entry; returns at next FETCH/IDLE/HALT entry
   task automatic run_one(input vec_t v);
      logic [3:0] op;
      int  cnt, nwe, nfwe;
      bit  left, done;
      op = v.instr[27:24];
      mem[exp_pc] = v.instr;
      cond_pass = v.cp; ldst_addr = v.ldst;
      fetch_wait = v.fw; mem_wait = v.mw; run = v.run_v;
      acc_q.push_back({1'b0, exp_pc});
      if (op == 4'd13) acc_q.push_back({1'b0, v.ldst});
      if (op == 4'd14) acc_q.push_back({1'b1, v.ldst});
      if (v.n_we > 0) wb_q.push_back({op == 4'd13, v.instr[22:19]});
      if (op == 4'd13) exp_ldr = mem[v.ldst];
      cnt = 0; nwe = 0; nfwe = 0; left = 0; done = 0;
      while (!done) begin
         if (reg_we) nwe++;
         if (flags_we) nfwe++;
         @(posedge clk); #1;
         cnt++;
         if (state != ST_FETCH) left = 1;
         if (left && (state == ST_FETCH || state == ST_IDLE || state == ST_HALT)) begin
            done = 1;
         end else if (cnt > 60) begin
            n_checks++; n_fail++;
            $display("FAIL instr_timeout: actual=%0d cycles required=%0d", cnt, v.lat);
            done = 1;
         end
      end
      exp_pc = v.next_pc;
      exp_ret += v.ret_inc;
      check("latency", 32'(cnt), 32'(v.lat));
      check("end_state", 32'(state), 32'(v.end_st));
      check("next_pc", 32'(pc), 32'(exp_pc));
      check("retired", 32'(retired), 32'(exp_ret % 16));
      check("reg_we_pulses", 32'(nwe), 32'(v.n_we));
      check("flags_we_pulses", 32'(nfwe), 32'(v.n_fwe));
      check("decode_fields", {op_code, dest, im_val, 8'h0}, {v.instr[27:24], v.instr[22:19],
                                                            v.instr[18:3], 8'h0});
      check("ldr_data", ldr_data, exp_ldr);
   endtask

   task automatic wait_state(input logic [2:0] st, input string name);
      int n;
      n = 0;
      while (state != st && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 32'(state), 32'(st));
   endtask

   vec_t tbl[9];
   vec_t b;
   int   nreq, nhalt;

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      mem[16'h0040] = 32'hDEADBEEF;
      mem[16'h0044] = 32'h0BADF00D;

      tbl[0] = '{instr: mk(4'd1, 1'b1, 4'd3, 16'h1234), cp: 0, ldst: 16'h0, fw: 0, mw: 0,
                 run_v: 1, lat: 4, next_pc: 16'h0001, n_we: 1, n_fwe: 1, ret_inc: 1,
                 end_st: ST_FETCH};
      tbl[1] = '{instr: mk(4'd2, 1'b0, 4'd4, 16'h0042), cp: 0, ldst: 16'h0, fw: 1, mw: 0,
                 run_v: 1, lat: 5, next_pc: 16'h0002, n_we: 1, n_fwe: 0, ret_inc: 1,
                 end_st: ST_FETCH};
      tbl[2] = '{instr: mk(4'd13, 1'b1, 4'd5, 16'h0000), cp: 0, ldst: 16'h0040, fw: 0, mw: 2,
                 run_v: 1, lat: 7, next_pc: 16'h0003, n_we: 1, n_fwe: 0, ret_inc: 1,
                 end_st: ST_FETCH};
      tbl[3] = '{instr: mk(4'd14, 1'b0, 4'd6, 16'h0000), cp: 0, ldst: 16'h0080, fw: 0, mw: 0,
                 run_v: 1, lat: 4, next_pc: 16'h0004, n_we: 0, n_fwe: 0, ret_inc: 1,
                 end_st: ST_FETCH};
      tbl[4] = '{instr: mk(4'd12, 1'b0, 4'd0, 16'h0010), cp: 1, ldst: 16'h0, fw: 0, mw: 0,
                 run_v: 1, lat: 3, next_pc: 16'h0010, n_we: 0, n_fwe: 0, ret_inc: 1,
                 end_st: ST_FETCH};
      tbl[5] = '{instr: mk(4'd12, 1'b0, 4'd0, 16'h0020), cp: 0, ldst: 16'h0, fw: 0, mw: 0,
                 run_v: 1, lat: 3, next_pc: 16'h0011, n_we: 0, n_fwe: 0, ret_inc: 1,
                 end_st: ST_FETCH};
      tbl[6] = '{instr: mk(4'd3, 1'b1, 4'd7, 16'h5555), cp: 0, ldst: 16'h0, fw: 0, mw: 0,
                 run_v: 1, lat: 4, next_pc: 16'h0012, n_we: 1, n_fwe: 1, ret_inc: 1,
                 end_st: ST_FETCH};
      tbl[7] = '{instr: mk(4'd12, 1'b1, 4'd0, 16'hFFFF), cp: 1, ldst: 16'h0, fw: 0, mw: 0,
                 run_v: 1, lat: 3, next_pc: 16'hFFFF, n_we: 0, n_fwe: 0, ret_inc: 1,
                 end_st: ST_FETCH};
      tbl[8] = '{instr: mk(4'd4, 1'b0, 4'd8, 16'h0000), cp: 0, ldst: 16'h0, fw: 0, mw: 0,
                 run_v: 1, lat: 4, next_pc: 16'h0000, n_we: 1, n_fwe: 0, ret_inc: 1,
                 end_st: ST_FETCH};

      // Reset values
      #1;
      check("rst_state", 32'(state), 32'(ST_IDLE));
      check("rst_pc_addr", {pc, mem_addr}, 32'h0);
      check("rst_strobes", 32'({mem_req, mem_rw, reg_we, flags_we, sel_ldr, halted}), 32'h0);
      check("rst_retired", 32'(retired), 32'h0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 check("idle_without_run", 32'({state, mem_req}), 32'({ST_IDLE, 1'b0}));
      run = 1'b1;
      @(posedge clk); #1;
      check("first_fetch", 32'(state), 32'(ST_FETCH));

      for (int i = 0; i < 9; i++) run_one(tbl[i]);

      // Not-taken branches carry the 4-bit retire counter through its wrap
      for (int i = 0; i < 8; i++) begin
         b = '{instr: mk(4'd12, 1'b0, 4'd0, 16'h0100), cp: 0, ldst: 16'h0, fw: 0, mw: 0,
               run_v: 1, lat: 3, next_pc: 16'(i + 1), n_we: 0, n_fwe: 0, ret_inc: 1,
               end_st: ST_FETCH};
         run_one(b);
      end
      check("retired_wrapped", 32'(retired), 32'h1);

      // Dropping run mid-instruction lets it finish, then idles
      b = '{instr: mk(4'd1, 1'b0, 4'd9, 16'h0000), cp: 0, ldst: 16'h0, fw: 0, mw: 0,
            run_v: 0, lat: 4, next_pc: 16'h0009, n_we: 1, n_fwe: 0, ret_inc: 1,
            end_st: ST_IDLE};
      run_one(b);
      repeat (3) @(posedge clk);
      #1 check("idle_hold", 32'({state, mem_req}), 32'({ST_IDLE, 1'b0}));

      // Reset asserted between edges while a load is waiting in MEM
      mem[16'h0009] = mk(4'd13, 1'b0, 4'd2, 16'h0000);
      ldst_addr = 16'h0044; mem_wait = 50; fetch_wait = 0;
      acc_q.push_back({1'b0, 16'h0009});
      run = 1'b1;
      wait_state(ST_MEM, "reach_mem");
      check("mem_req_in_mem", 32'({mem_req, mem_rw, mem_addr}), 32'({1'b1, 1'b0, 16'h0044}));
      @(negedge clk); #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_req", 32'({mem_req, mem_rw, reg_we, flags_we, sel_ldr, halted}), 32'h0);
      check("async_rst_state", 32'(state), 32'(ST_IDLE));
      check("async_rst_pc", {pc, mem_addr}, 32'h0);
      check("async_rst_regs", 32'({retired, op_code, dest, im_val}), 32'h0);
      check("async_rst_ldr", ldr_data, 32'h0);
      acc_q.delete(); wb_q.delete();
      exp_pc = '0; exp_ret = 0; exp_ldr = '0;
      run = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_idle", 32'(state), 32'(ST_IDLE));
      run = 1'b1;
      wait_state(ST_FETCH, "refetch");

      // HALT is absorbing and never retires or requests memory
      b = '{instr: mk(4'd15, 1'b1, 4'd1, 16'h0000), cp: 0, ldst: 16'h0, fw: 0, mw: 0,
            run_v: 1, lat: 3, next_pc: 16'h0001, n_we: 0, n_fwe: 0, ret_inc: 0,
            end_st: ST_HALT};
      run_one(b);
      nreq = 0; nhalt = 0;
      for (int i = 0; i < 20; i++) begin
         if (mem_req || reg_we || flags_we) nreq++;
         if (halted && state == ST_HALT) nhalt++;
         @(posedge clk); #1;
      end
      check("halt_no_activity", 32'(nreq), 32'h0);
      check("halt_held", 32'(nhalt), 32'd20);
      check("halt_retired", 32'(retired), 32'h0);
      check("sb_drained", 32'(acc_q.size() + wb_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
